// File: rtl/verifier_pkg.sv
// Field definitions and modular helpers shared by the chi evaluator and its lanes.
// Field is GF(65521); all helpers expect reduced operands unless noted.
package verifier_pkg;
  localparam int F_NBITS = 16;
  typedef logic [F_NBITS-1:0] fe_t;
  localparam fe_t F_Q       = 16'd65521;
  // ~t + F_Q_P2_MI == 2*F_Q + 1 - t, i.e. 1-t before reduction
  localparam fe_t F_Q_P2_MI = 16'd65508;

  typedef enum logic [1:0] {L_IDLE, L_SEED, L_EXP, L_DOT} lane_state_e;
  typedef enum logic {T_IDLE, T_RUN} top_state_e;

  function automatic fe_t fe_add(input fe_t a, input fe_t b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic fe_t fe_sub(input fe_t a, input fe_t b);
    return (a >= b) ? a - b : a + (F_Q - b);
  endfunction

  // Accepts any t, including t >= F_Q
  function automatic fe_t fe_one_minus(input fe_t t);
    logic [F_NBITS:0] s;
    s = {1'b0, ~t} + {1'b0, F_Q_P2_MI};
    if (s >= {F_Q, 1'b0}) s = s - {F_Q, 1'b0};
    else if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  // One MSB-first shift-add multiplier step: (2*acc + addend) mod F_Q
  function automatic fe_t fe_mac2(input fe_t acc, input fe_t addend);
    logic [F_NBITS+1:0] s;
    s = {1'b0, acc, 1'b0} + {2'b00, addend};
    if (s >= {1'b0, F_Q, 1'b0}) s = s - {1'b0, F_Q, 1'b0};
    else if (s >= {2'b00, F_Q}) s = s - {2'b00, F_Q};
    return s[F_NBITS-1:0];
  endfunction
endpackage

// File: rtl/verifier_compute_chi_lane.sv
// One chi lane: seeds from the lane-bit factors, expands the slot bits in place,
// then accumulates its dot-product partial, all through one serial multiplier.
module verifier_compute_chi_lane
  import verifier_pkg::*;
#(
  parameter int nValBits     = 6,
  parameter int nParBits     = 2,
  parameter int nEarlyBits   = 4,
  parameter int doDotProduct = 1,
  parameter int LANE         = 0,
  localparam int NSLOT = 2 ** (nValBits - nParBits),
  localparam int SW    = (nValBits > nParBits) ? nValBits - nParBits : 1,
  localparam int TW    = $clog2(nValBits + 1)
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        go,
  input  logic        early,
  input  fe_t         tau [nValBits],
  input  fe_t         vals [NSLOT],
  output fe_t         chi [NSLOT],
  output fe_t         dot_part,
  output lane_state_e state
);
  lane_state_e   st, nxt;
  logic [TW-1:0] n_slot_bits, cnt, tsel;
  logic [SW-1:0] idx, lo_i, hi_i, last_i;
  logic          wait_q, mul_go, mbusy, mdone, lane_bit;
  logic [4:0]    mcnt;
  fe_t           ma, mb, macc, mul_a, mul_b, t_coord, acc;

  assign n_slot_bits = early ? TW'(nEarlyBits - nParBits) : TW'(nValBits - nParBits);
  assign last_i      = early ? SW'((1 << (nEarlyBits - nParBits)) - 1) : SW'(NSLOT - 1);
  assign lo_i        = idx << 1;
  assign hi_i        = lo_i | SW'(1);
  // Lane-bit coordinates sit directly above the slot-bit coordinates
  assign tsel        = (st == L_SEED) ? n_slot_bits + cnt : cnt;
  assign lane_bit    = ((LANE >> cnt) & 1) != 0;
  assign dot_part    = acc;
  assign state       = st;

  always_comb begin
    t_coord = '0;
    for (int j = 0; j < nValBits; j++)
      if (tsel == TW'(j)) t_coord = tau[j];
  end

  always_comb begin
    nxt    = st;
    mul_go = 1'b0;
    mul_a  = chi[idx];
    mul_b  = t_coord;
    case (st)
      L_IDLE: if (go) nxt = L_SEED;
      L_SEED: begin
        mul_a = chi[0];
        mul_b = lane_bit ? t_coord : fe_one_minus(t_coord);
        if (int'(cnt) >= nParBits) nxt = (n_slot_bits == '0) ? L_DOT : L_EXP;
        else mul_go = !wait_q;
      end
      L_EXP: begin
        mul_go = !wait_q;
        if (mdone && idx == '0 && cnt == '0) nxt = L_DOT;
      end
      L_DOT: begin
        mul_b = vals[idx];
        if (doDotProduct == 0) nxt = L_IDLE;
        else begin
          mul_go = !wait_q;
          if (mdone && idx == last_i) nxt = L_IDLE;
        end
      end
      default: nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      st     <= L_IDLE;
      wait_q <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      acc    <= '0;
      for (int i = 0; i < NSLOT; i++) chi[i] <= '0;
    end else begin
      st <= nxt;
      if (mul_go) wait_q <= 1'b1;
      else if (mdone) wait_q <= 1'b0;
      case (st)
        L_IDLE: if (go) begin
          chi[0] <= fe_t'(1);
          cnt    <= '0;
          idx    <= '0;
          acc    <= '0;
        end
        L_SEED: begin
          if (mdone) begin
            chi[0] <= macc;
            cnt    <= cnt + TW'(1);
          end
          if (nxt == L_EXP) cnt <= n_slot_bits - TW'(1);
          if (nxt != L_SEED) idx <= '0;
        end
        // Parents are walked high-to-low so children never overwrite unread parents
        L_EXP: if (mdone) begin
          chi[hi_i] <= macc;
          chi[lo_i] <= fe_sub(chi[idx], macc);
          if (idx != '0) idx <= idx - SW'(1);
          else if (cnt != '0) begin
            idx <= SW'((1 << (int'(n_slot_bits) - int'(cnt))) - 1);
            cnt <= cnt - TW'(1);
          end
        end
        L_DOT: if (mdone) begin
          acc <= fe_add(acc, macc);
          idx <= idx + SW'(1);
        end
        default: ;
      endcase
    end
  end

  // Serial multiplier: mul_go loads, mdone pulses one cycle with macc = a*b mod F_Q
  always_ff @(posedge clk) begin
    if (rstb) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
      mcnt  <= '0;
      ma    <= '0;
      mb    <= '0;
      macc  <= '0;
    end else begin
      mdone <= mbusy && (mcnt == 5'd1);
      if (mul_go) begin
        ma    <= (mul_a >= F_Q) ? mul_a - F_Q : mul_a;
        mb    <= mul_b;
        macc  <= '0;
        mcnt  <= 5'(F_NBITS);
        mbusy <= 1'b1;
      end else if (mbusy) begin
        macc <= fe_mac2(macc, mb[F_NBITS-1] ? ma : '0);
        mb   <= mb << 1;
        mcnt <= mcnt - 5'd1;
        if (mcnt == 5'd1) mbusy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/verifier_compute_chi.sv
// Verifier-side chi evaluation over GF(q): captures inputs, fans the run out
// to 2^nParBits lanes, and sums the lane dot-product partials.
module verifier_compute_chi
  import verifier_pkg::*;
#(
  parameter int nValBits     = 6,
  parameter int nParBits     = 2,
  parameter int nEarlyBits   = 4,
  parameter int doDotProduct = 1,
  localparam int NVALUES = 2 ** nValBits
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  logic early,
  input  fe_t  tau [nValBits],
  input  fe_t  vals_in [NVALUES],
  output fe_t  dot_product_out,
  output fe_t  chi_out [NVALUES],
  output logic ready
);
  localparam int NPAR  = 2 ** nParBits;
  localparam int NSLOT = 2 ** (nValBits - nParBits);

  // Handshake: a run starts on any posedge with ready=1 and en=1; ready drops the
  // next cycle and rises again only when chi_out and dot_product_out are final.
  top_state_e  state, state_nxt;
  logic        start, all_ready, early_q;
  logic [NPAR-1:0] lane_ready;
  lane_state_e lane_state [NPAR];
  fe_t         tau_q [nValBits];
  fe_t         vals_q [NVALUES];
  fe_t         lane_vals [NPAR][NSLOT];
  fe_t         lane_chi [NPAR][NSLOT];
  fe_t         lane_dot [NPAR];
  fe_t         dot_sum, dot_q;

  assign start           = (state == T_IDLE) && en;
  assign ready           = (state == T_IDLE);
  assign all_ready       = &lane_ready;
  assign dot_product_out = dot_q;

  always_comb begin
    state_nxt = state;
    case (state)
      T_IDLE:  if (en) state_nxt = T_RUN;
      T_RUN:   if (all_ready) state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state   <= T_IDLE;
      early_q <= 1'b0;
      dot_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start) early_q <= early;
      if (state == T_RUN && all_ready) dot_q <= dot_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      tau_q  <= tau;
      vals_q <= vals_in;
    end
  end

  always_comb begin
    dot_sum = '0;
    for (int g = 0; g < NPAR; g++) begin
      lane_ready[g] = (lane_state[g] == L_IDLE);
      dot_sum       = fe_add(dot_sum, lane_dot[g]);
      for (int i = 0; i < NSLOT; i++) begin
        lane_vals[g][i]        = vals_q[g*NSLOT+i];
        chi_out[g*NSLOT+i]     = lane_chi[g][i];
      end
    end
  end

  for (genvar g = 0; g < NPAR; g++) begin : g_lane
    verifier_compute_chi_lane #(
      .nValBits     (nValBits),
      .nParBits     (nParBits),
      .nEarlyBits   (nEarlyBits),
      .doDotProduct (doDotProduct),
      .LANE         (g)
    ) u_lane (
      .clk      (clk),
      .rstb     (rstb),
      .go       (start),
      .early    (early_q),
      .tau      (tau_q),
      .vals     (lane_vals[g]),
      .chi      (lane_chi[g]),
      .dot_part (lane_dot[g]),
      .state    (lane_state[g])
    );
  end
endmodule

// File: tb/tb_verifier_compute_chi.sv
// Bench for verifier_compute_chi: directed vector table, random back-to-back runs,
// and reset corner cases, all checked against a product-form chi model.
module tb_verifier_compute_chi;
  import verifier_pkg::*;

  localparam int NV = 6, NP = 2, NE = 4, NVALS = 64, NSLOT = 16;
  localparam longint Q = longint'(F_Q);

  logic clk = 1'b0;
  logic rstb, en, early, ready, ready0;
  fe_t  tau [NV];
  fe_t  vals_in [NVALS];
  fe_t  chi_out [NVALS];
  fe_t  chi_out0 [NVALS];
  fe_t  dot, dot0;

  int n_checks = 0;
  int n_fail = 0;
  logic [F_NBITS-1:0] exp_q[$];
  fe_t  m_tau [NV];
  fe_t  m_vals [NVALS];
  logic m_early;

  typedef struct {
    logic early;
    int   tau_v;
    int   v0;
    int   idx;
    int   exp_chi;
    logic chk_dot;
    int   exp_dot;
  } vec_t;
  vec_t vecs [10];

  verifier_compute_chi #(.nValBits(NV), .nParBits(NP), .nEarlyBits(NE), .doDotProduct(1)) dut (
    .clk(clk), .rstb(rstb), .en(en), .early(early), .tau(tau), .vals_in(vals_in),
    .dot_product_out(dot), .chi_out(chi_out), .ready(ready));

  verifier_compute_chi #(.nValBits(NV), .nParBits(NP), .nEarlyBits(NE), .doDotProduct(0)) dut0 (
    .clk(clk), .rstb(rstb), .en(en), .early(early), .tau(tau), .vals_in(vals_in),
    .dot_product_out(dot0), .chi_out(chi_out0), .ready(ready0));

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint chi_ref(input int x, input int nb);
    longint p = 1;
    for (int j = 0; j < nb; j++) begin
      longint t = longint'(m_tau[j]) % Q;
      longint f = ((x >> j) & 1) != 0 ? t : (1 - t + Q) % Q;
      p = (p * f) % Q;
    end
    return p;
  endfunction

  function automatic int out_idx(input int x);
    return m_early ? (x >> (NE - NP)) * NSLOT + (x & ((1 << (NE - NP)) - 1)) : x;
  endfunction

  // Driver tasks
  task automatic apply_model_inputs();
    early = m_early;
    for (int j = 0; j < NV; j++) tau[j] = m_tau[j];
    for (int i = 0; i < NVALS; i++) vals_in[i] = m_vals[i];
  endtask

  task automatic start_run(input int hold);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("ready_low_after_start", {31'd0, ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      early = ~early;
      for (int j = 0; j < NV; j++) tau[j] = fe_t'($urandom);
      for (int i = 0; i < NVALS; i++) vals_in[i] = fe_t'($urandom);
      @(negedge clk);
      check("ready_low_while_en_held", {31'd0, ready}, 32'd0);
    end
    en = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!(ready && ready0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL run_timeout: ready=%0d ready0=%0d after %0d cycles", ready, ready0, cyc);
    end
  endtask

  // Scoreboard: expected chi then dot pushed, popped against both DUTs
  task automatic check_all();
    int nb = m_early ? NE : NV;
    longint dsum = 0;
    for (int x = 0; x < (1 << nb); x++) begin
      longint c = chi_ref(x, nb);
      exp_q.push_back(F_NBITS'(c));
      dsum = (dsum + c * (longint'(m_vals[out_idx(x)]) % Q)) % Q;
    end
    exp_q.push_back(F_NBITS'(dsum));
    for (int x = 0; x < (1 << nb); x++) begin
      logic [F_NBITS-1:0] e = exp_q.pop_front();
      check($sformatf("chi[%0d]", out_idx(x)), {16'd0, chi_out[out_idx(x)]}, {16'd0, e});
      check($sformatf("chi0[%0d]", out_idx(x)), {16'd0, chi_out0[out_idx(x)]}, {16'd0, e});
    end
    check("dot_product", {16'd0, dot}, {16'd0, exp_q.pop_front()});
    check("dot_product_disabled", {16'd0, dot0}, 32'd0);
  endtask

  task automatic check_zeroed(input string name);
    int nz = 0;
    for (int i = 0; i < NVALS; i++) if (chi_out[i] != '0 || chi_out0[i] != '0) nz++;
    check({name, "_ready"}, {30'd0, ready, ready0}, 32'd3);
    check({name, "_chi_nonzero"}, nz, 0);
    check({name, "_dot"}, {16'd0, dot}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 0, 7, 0,  1,     1'b1, 7};
    vecs[1] = '{1'b0, 0, 7, 37, 0,     1'b1, 7};
    vecs[2] = '{1'b0, 1, 7, 63, 1,     1'b0, 0};
    vecs[3] = '{1'b0, 1, 7, 62, 0,     1'b0, 0};
    vecs[4] = '{1'b0, 2, 7, 0,  1,     1'b0, 0};
    vecs[5] = '{1'b0, 2, 7, 63, 64,    1'b0, 0};
    vecs[6] = '{1'b0, 2, 7, 1,  65519, 1'b0, 0};
    vecs[7] = '{1'b1, 1, 7, 51, 1,     1'b0, 0};
    vecs[8] = '{1'b1, 1, 7, 48, 0,     1'b0, 0};
    vecs[9] = '{1'b1, 0, 9, 0,  1,     1'b1, 9};

    // Reset, with en high to show reset wins
    rstb = 1'b1;
    en = 1'b1;
    early = 1'b0;
    for (int j = 0; j < NV; j++) tau[j] = '0;
    for (int i = 0; i < NVALS; i++) vals_in[i] = '0;
    repeat (3) @(negedge clk);
    check_zeroed("reset");
    en = 1'b0;
    rstb = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {31'd0, ready}, 32'd1);

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      m_early = vecs[v].early;
      for (int j = 0; j < NV; j++) m_tau[j] = fe_t'(vecs[v].tau_v);
      for (int i = 0; i < NVALS; i++) m_vals[i] = fe_t'($urandom);
      m_vals[0] = fe_t'(vecs[v].v0);
      apply_model_inputs();
      start_run(0);
      wait_done();
      check($sformatf("vec%0d_chi[%0d]", v, vecs[v].idx),
            {16'd0, chi_out[vecs[v].idx]}, vecs[v].exp_chi);
      if (vecs[v].chk_dot) check($sformatf("vec%0d_dot", v), {16'd0, dot}, vecs[v].exp_dot);
      check_all();
    end

    // Random back-to-back runs, en held two extra cycles with scrambled inputs
    for (int r = 0; r < 8; r++) begin
      m_early = (r % 2) != 0;
      for (int j = 0; j < NV; j++)
        m_tau[j] = ($urandom_range(0, 3) == 0) ? fe_t'($urandom_range(int'(F_Q), 65535))
                                                : fe_t'($urandom);
      for (int i = 0; i < NVALS; i++) m_vals[i] = fe_t'($urandom);
      apply_model_inputs();
      start_run(2);
      wait_done();
      check_all();
    end

    // Reset in the middle of a run, then a clean run afterwards
    m_early = 1'b0;
    for (int j = 0; j < NV; j++) m_tau[j] = fe_t'($urandom);
    for (int i = 0; i < NVALS; i++) m_vals[i] = fe_t'($urandom);
    apply_model_inputs();
    start_run(0);
    repeat (40) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    check_zeroed("midrun_reset");
    apply_model_inputs();
    start_run(0);
    wait_done();
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
